hilo_muldiv: RTL
================

HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, data width of operands and of each of HI and LO; legal values 8..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op_valid  input  1  operation request.
REQ-005 op_code  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved.
REQ-006 src_a  input  WIDTH  multiplicand / dividend / move data.
REQ-007 src_b  input  WIDTH  multiplier / divisor.
REQ-008 flush  input  1  abort the in-flight operation.
REQ-009 op_ready  output  1  high only in IDLE.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 div0  output  1  qualifies done: divisor was zero.
REQ-013 hi, lo  output  WIDTH each  registered HI/LO contents.

Function
REQ-014 An operation SHALL be accepted on a rising edge where op_valid && op_ready && !flush.
REQ-015 States SHALL be IDLE, DIV_RUN and DIV_FIX; MULT, MULTU, MTHI and MTLO SHALL complete from IDLE without leaving IDLE.
REQ-016 MTHI/MTLO SHALL write src_a to hi/lo on the accepting edge; the other register SHALL be unchanged.
REQ-017 MULT/MULTU SHALL write the 2*WIDTH signed/unsigned product {hi,lo} on the accepting edge.
REQ-018 DIV/DIVU with src_b != 0 SHALL go IDLE->DIV_RUN, spend exactly WIDTH cycles in DIV_RUN producing one quotient bit per cycle, then spend one cycle in DIV_FIX.
REQ-019 DIV_FIX SHALL apply sign correction, write lo=quotient and hi=remainder on its exiting edge, and return to IDLE.
REQ-020 Signed quotient SHALL truncate toward zero; the remainder SHALL take the sign of the dividend; MIN/-1 SHALL give lo=MIN, hi=0.
REQ-021 DIV/DIVU with src_b == 0 SHALL stay in IDLE, leave hi/lo unchanged, and pulse done with div0=1 in the next cycle.
REQ-022 done SHALL be high for exactly the one cycle following the edge on which the result is written, or on which the div0 decision is taken; div0 SHALL be low whenever done is low.
REQ-023 Divide latency: accepted at edge E, hi/lo updated at edge E+WIDTH+1, done high in cycle E+WIDTH+1..E+WIDTH+2.
REQ-024 Reserved op_codes SHALL be accepted as no-ops, with no done pulse and hi/lo unchanged.
REQ-025 Operands SHALL be captured at acceptance; src_a/src_b changes while busy SHALL have no effect.
REQ-026 flush while busy SHALL return to IDLE on the next edge with hi/lo unchanged and no done pulse.
REQ-027 flush in IDLE SHALL block acceptance.
REQ-028 flush SHALL also suppress a done pulse that would occur in the same cycle.

Reset
REQ-029 reset SHALL force IDLE, hi=0, lo=0, done=0, div0=0, aborting any division; reset SHALL have priority over flush and op_valid.

Configuration
REQ-030 Macro HILO_DIV_EN SHALL compile the divider in, giving REQ-018 to REQ-023 behaviour.
REQ-031 Without HILO_DIV_EN, DIV_RUN/DIV_FIX SHALL not exist, and DIV/DIVU SHALL be accepted in IDLE, leave hi/lo unchanged and pulse done with div0=1 next cycle.

Structure
REQ-032 Package hilo_pkg SHALL hold the op_code enumeration, the state enumeration and the WIDTH default constant.
REQ-033 The iterative restoring divider SHALL be a sub-module hilo_div_core with start/abort/done handshake; multiply and move logic SHALL stay in hilo_muldiv.

Verification (WIDTH=32, HILO_DIV_EN defined unless stated)
REQ-034 MULT a=0xFFFFFFFE b=3 -> hi=0xFFFFFFFF lo=0xFFFFFFFA next cycle, done pulse; MULTU same operands -> hi=0x00000002 lo=0xFFFFFFFA.
REQ-035 DIV a=0xFFFFFFF9 (-7) b=2 -> op_ready low for 33 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF, single done pulse, div0=0; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-036 DIVU a=100 b=0 after MTHI 0x12345678 -> done=1 div0=1 next cycle, hi=0x12345678 unchanged, never busy.
REQ-037 DIVU 100/7 with flush on 10th DIV_RUN cycle -> IDLE next edge, no done, hi/lo unchanged; a following MTLO 0xA5A5A5A5 is accepted immediately.
REQ-038 reset asserted mid-division after MTHI/MTLO -> hi=lo=0, busy=0, no done pulse; without HILO_DIV_EN, DIV 9/3 -> done+div0 next cycle, hi/lo unchanged.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: operation codes,
// controller states and the default datapath width.
package hilo_pkg;

  localparam int HILO_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_RUN = 2'd1,
    ST_DIV_FIX = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_div_core.sv
// Iterative restoring divider, one quotient bit per clock.
// Operates on magnitudes; the sign of quotient and remainder is restored
// from flags captured at start, so MIN / -1 wraps back to MIN with remainder 0.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_DIV_RUN | WIDTH shift/subtract steps, counted down to zero
// ST_DIV_FIX | sign-corrected result valid for one cycle (done high)
module hilo_div_core
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvsr_r;
  logic             neg_q;
  logic             neg_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  assign a_neg  = is_signed && dividend[WIDTH-1];
  assign b_neg  = is_signed && divisor[WIDTH-1];
  assign a_mag  = a_neg ? -dividend : dividend;
  assign b_mag  = b_neg ? -divisor : divisor;

  // Trial subtraction of the divisor from the partial remainder shifted by one bit.
  assign rem_sh = {rem_r, quo_r[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvsr_r};

  // Divider sequencing and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      quo_r  <= '0;
      rem_r  <= '0;
      dvsr_r <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_DIV_RUN;
            cnt    <= CNT_W'(WIDTH - 1);
            quo_r  <= a_mag;
            rem_r  <= '0;
            dvsr_r <= b_mag;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
          end
        end
        ST_DIV_RUN: begin
          quo_r <= {quo_r[WIDTH-2:0], ~diff[WIDTH]};
          rem_r <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          if (cnt == '0) begin
            state <= ST_DIV_FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DIV_FIX: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DIV_FIX);
  assign quotient  = neg_q ? -quo_r : quo_r;
  assign remainder = neg_r ? -rem_r : rem_r;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit. Multiplies and moves finish on the accepting
// edge; divides run in hilo_div_core when HILO_DIV_EN is defined. Without
// HILO_DIV_EN every divide is answered next cycle with done+div0 and HI/LO
// left untouched.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  op_e                      op;
  logic                     accept;
  logic                     div_busy;
  logic                     done_r;
  logic                     div0_r;
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;

  assign op       = op_e'(op_code);
  assign accept   = op_valid && op_ready && !flush;
  assign op_ready = !div_busy;
  assign busy     = div_busy;

  assign a_ext  = {{WIDTH{src_a[WIDTH-1]}}, src_a};
  assign b_ext  = {{WIDTH{src_b[WIDTH-1]}}, src_b};
  assign prod_s = a_ext * b_ext;
  assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

`ifdef HILO_DIV_EN
  logic             b_zero;
  logic             div_start;
  logic             div_fin;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  assign b_zero    = (src_b == '0);
  assign div_start = accept && ((op == OP_DIV) || (op == OP_DIVU)) && !b_zero;

  hilo_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .abort     (flush),
    .is_signed (op == OP_DIV),
    .dividend  (src_a),
    .divisor   (src_b),
    .busy      (div_busy),
    .done      (div_fin),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`else
  assign div_busy = 1'b0;
`endif

  // HI/LO update and registered completion flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      done_r <= 1'b0;
      div0_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      div0_r <= 1'b0;
      if (accept) begin
        case (op)
          OP_MULT: begin
            {hi, lo} <= prod_s;
            done_r   <= 1'b1;
          end
          OP_MULTU: begin
            {hi, lo} <= prod_u;
            done_r   <= 1'b1;
          end
          OP_MTHI: begin
            hi     <= src_a;
            done_r <= 1'b1;
          end
          OP_MTLO: begin
            lo     <= src_a;
            done_r <= 1'b1;
          end
          OP_DIV, OP_DIVU: begin
`ifdef HILO_DIV_EN
            // Non-zero divisors start the core; the result arrives later.
            if (b_zero) begin
              done_r <= 1'b1;
              div0_r <= 1'b1;
            end
`else
            done_r <= 1'b1;
            div0_r <= 1'b1;
`endif
          end
          default: ;
        endcase
      end
`ifdef HILO_DIV_EN
      else if (div_fin && !flush) begin
        hi     <= div_rem;
        lo     <= div_quo;
        done_r <= 1'b1;
      end
`endif
    end
  end

  // A flush in the completion cycle hides the pulse.
  assign done = done_r && !flush;
  assign div0 = div0_r && !flush;

endmodule
